// File: rtl/push_key_scanner.sv
// Push-button scanner: synchronize, debounce, and queue press/release events.
// Ports: CLK/RST, PUSH raw active-low keys, KEY_STATE debounced levels,
//   EVT_* show-ahead event FIFO head with VALID/READY, EVT_OVF sticky drop
//   flag cleared by OVF_CLR. Define KEY_REPEAT_EN for held-key auto-repeat.
module push_key_scanner #(
  parameter int NUM_KEYS      = 4,
  parameter int KEY_W         = 2,
  parameter int DB_CYCLES     = 500000,
  parameter int CNT_W         = 19,
  parameter int FIFO_AW       = 2,
  parameter int REPEAT_CYCLES = 25000000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_KEYS-1:0] PUSH,
  output logic [NUM_KEYS-1:0] KEY_STATE,
  output logic                EVT_VALID,
  input  logic                EVT_READY,
  output logic [KEY_W-1:0]    EVT_KEY,
  output logic                EVT_PRESS,
  output logic                EVT_OVF,
  input  logic                OVF_CLR
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DB_CYCLES);

  if ((1 << KEY_W) < NUM_KEYS) begin : g_bad_key_w
    $error("KEY_W too small for NUM_KEYS");
  end
  if (DB_CYCLES < 2 * NUM_KEYS) begin : g_bad_db
    $error("DB_CYCLES must be >= 2*NUM_KEYS");
  end
  if ((64'd1 << CNT_W) <= 64'(DB_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too small for DB_CYCLES");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rep
    $error("REPEAT_CYCLES must be positive");
  end

  typedef enum logic {STABLE, QUALIFY} db_t;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] sync_n;
  db_t                 state [NUM_KEYS];
  logic [CNT_W-1:0]    cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] qual;
  logic [NUM_KEYS-1:0] rep;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] pend_type;
  logic [NUM_KEYS-1:0] clr;
  logic                wr;
  logic [KEY_W-1:0]    wr_idx;
  logic                wr_type;

  logic [FIFO_AW:0]    wptr;
  logic [FIFO_AW:0]    rptr;
  logic [KEY_W:0]      mem [DEPTH];
  logic                empty;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= PUSH;
      sync2 <= sync1;
    end
  end

  assign sync_n = ~sync2;

  // Final qualifying cycle of a key: still disagreeing at full count.
  always_comb begin
    qual = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      qual[i] = (state[i] == QUALIFY) &&
                (sync_n[i] != KEY_STATE[i]) &&
                (cnt[i] == DB_MAX);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= '0;
      end
      KEY_STATE <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        unique case (state[i])
          STABLE: begin
            if (sync_n[i] != KEY_STATE[i]) begin
              state[i] <= QUALIFY;
              cnt[i]   <= CNT_W'(1);
            end
          end
          QUALIFY: begin
            if (sync_n[i] == KEY_STATE[i]) begin
              state[i] <= STABLE;
              cnt[i]   <= '0;
            end else if (qual[i]) begin
              KEY_STATE[i] <= sync_n[i];
              state[i]     <= STABLE;
              cnt[i]       <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rcnt [NUM_KEYS];

  always_comb begin
    rep = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      rep[i] = KEY_STATE[i] && !qual[i] && (rcnt[i] == REP_MAX);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_KEYS; i++) rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (!KEY_STATE[i] || qual[i] || rep[i]) begin
          rcnt[i] <= '0;
        end else begin
          rcnt[i] <= rcnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign rep = '0;
`endif

  // Lowest-index pending key wins the single write slot.
  always_comb begin
    wr      = 1'b0;
    wr_idx  = '0;
    wr_type = 1'b0;
    clr     = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        wr      = 1'b1;
        wr_idx  = KEY_W'(i);
        wr_type = pend_type[i];
        clr     = '0;
        clr[i]  = 1'b1;
      end
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                 (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign pop   = !empty && EVT_READY;
  assign push  = wr && (!full || pop);
  assign drop  = wr && full && !pop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr      <= '0;
      rptr      <= '0;
      pending   <= '0;
      pend_type <= '0;
      EVT_OVF   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr[FIFO_AW-1:0]] <= {wr_idx, wr_type};
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      // A repeat hitting an undrained bit simply merges into it.
      pending <= (pending & ~clr) | qual | rep;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (qual[i]) begin
          pend_type[i] <= sync_n[i];
        end else if (rep[i]) begin
          pend_type[i] <= 1'b1;
        end
      end
      if (drop) begin
        EVT_OVF <= 1'b1;
      end else if (OVF_CLR) begin
        EVT_OVF <= 1'b0;
      end
    end
  end

  assign EVT_VALID            = !empty;
  assign {EVT_KEY, EVT_PRESS} = mem[rptr[FIFO_AW-1:0]];

endmodule

// File: tb/tb_push_key_scanner.sv
// Self-checking bench for push_key_scanner: directed scenarios plus
// randomized key/handshake activity compared against a queue-based model.
module tb_push_key_scanner;

  localparam int NK    = 4;
  localparam int KW    = 2;
  localparam int DB    = 16;
  localparam int CW    = 5;
  localparam int AW    = 2;
  localparam int REP   = 40;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] push = '1;
  logic          ready = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [NK-1:0] key_state;
  logic          evt_valid;
  logic [KW-1:0] evt_key;
  logic          evt_press;
  logic          evt_ovf;

  int checks = 0;
  int passes = 0;

  push_key_scanner #(
    .NUM_KEYS(NK), .KEY_W(KW), .DB_CYCLES(DB), .CNT_W(CW),
    .FIFO_AW(AW), .REPEAT_CYCLES(REP)
  ) dut (
    .CLK(clk), .RST(rst), .PUSH(push), .KEY_STATE(key_state),
    .EVT_VALID(evt_valid), .EVT_READY(ready), .EVT_KEY(evt_key),
    .EVT_PRESS(evt_press), .EVT_OVF(evt_ovf), .OVF_CLR(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a key flips once its synchronized level has disagreed
  // with the accepted level on DB+1 consecutive edges; events go through a
  // bounded queue with drop-on-full.
  logic [NK-1:0] h1, h2, m_st, m_pend, m_ptype;
  int            m_run [NK];
  int            m_rc [NK];
  logic [KW:0]   m_q [$];
  logic          m_ovf;
  int            m_drops;

  always @(posedge clk or posedge rst) begin
    int w;
    bit full, do_pop, drop, qi;
    if (rst) begin
      h1 = '1; h2 = '1;
      m_st = '0; m_pend = '0; m_ptype = '0;
      m_q.delete();
      m_ovf = 1'b0;
      for (int i = 0; i < NK; i++) begin
        m_run[i] = 0; m_rc[i] = 0;
      end
    end else begin
      w = -1;
      for (int i = NK - 1; i >= 0; i--) if (m_pend[i]) w = i;
      full = (m_q.size() == DEPTH);
      do_pop = (m_q.size() != 0) && ready;
      drop = 1'b0;
      if (do_pop) void'(m_q.pop_front());
      if (w >= 0) begin
        m_pend[w] = 1'b0;
        if (full && !do_pop) begin
          drop = 1'b1;
          m_drops++;
        end else begin
          m_q.push_back({KW'(w), m_ptype[w]});
        end
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      for (int i = 0; i < NK; i++) begin
        qi = 1'b0;
        if (~h2[i] != m_st[i]) begin
          m_run[i]++;
          if (m_run[i] == DB + 1) begin
            qi = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
`ifdef KEY_REPEAT_EN
        if (!m_st[i] || qi) begin
          m_rc[i] = 0;
        end else begin
          m_rc[i]++;
          if (m_rc[i] == REP) begin
            m_rc[i] = 0;
            m_pend[i] = 1'b1;
            m_ptype[i] = 1'b1;
          end
        end
`endif
        if (qi) begin
          m_st[i] = ~m_st[i];
          m_pend[i] = 1'b1;
          m_ptype[i] = m_st[i];
        end
      end
      h2 = h1;
      h1 = push;
    end
  end

  function automatic logic [NK+KW+2:0] obs();
    logic [KW:0] h;
    h = evt_valid ? {evt_key, evt_press} : '0;
    return {key_state, evt_valid, h, evt_ovf};
  endfunction

  function automatic logic [NK+KW+2:0] expv();
    logic [KW:0] h;
    logic v;
    v = (m_q.size() != 0);
    h = '0;
    if (v) h = m_q[0];
    return {m_st, v, h, m_ovf};
  endfunction

  task automatic settle();
    push = '1;
    ready = 1'b1;
    repeat (2 * DB + 10) @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    repeat (2) @(negedge clk);
    checks++;
    if ({key_state, evt_valid, evt_key, evt_press, evt_ovf} !== '0)
      $display("FAIL reset_state: got %h want 0",
               {key_state, evt_valid, evt_key, evt_press, evt_ovf});
    else passes++;
    rst = 1'b0;
    push[1] = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({key_state, evt_valid, evt_key, evt_press, evt_ovf} !== '0)
      $display("FAIL reset_mid_qual: got %h want 0",
               {key_state, evt_valid, evt_key, evt_press, evt_ovf});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!key_state[1] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n - 1 !== 18)
      $display("FAIL requalify_latency: got %0d edges want 18", n - 1);
    else passes++;
    @(negedge clk);
    settle();
  endtask

  task automatic test_clean_press();
    int n;
    ready = 1'b0;
    @(negedge clk);
    push[2] = 1'b0;
    n = 0;
    while (!key_state[2] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n - 1 !== 18)
      $display("FAIL press_latency: got %0d edges want 18", n - 1);
    else passes++;
    n = 0;
    while (!evt_valid && n < 5) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n !== 1) $display("FAIL valid_latency: got %0d want 1", n);
    else passes++;
    checks++;
    if ({evt_key, evt_press} !== {2'd2, 1'b1})
      $display("FAIL press_event: got %b want 101", {evt_key, evt_press});
    else passes++;
    repeat (5) @(negedge clk);
    checks++;
    if ({evt_valid, evt_key, evt_press} !== {1'b1, 2'd2, 1'b1})
      $display("FAIL head_hold: got %b want 1101",
               {evt_valid, evt_key, evt_press});
    else passes++;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0) $display("FAIL pop_empty: got %b want 0", evt_valid);
    else passes++;
    push[2] = 1'b1;
    n = 0;
    while (!evt_valid && n < 40) begin
      @(negedge clk); n++;
    end
    checks++;
    if ({evt_valid, evt_key, evt_press, key_state[2]} !== {1'b1, 2'd2, 2'b00})
      $display("FAIL release_event: got %b want 11000",
               {evt_valid, evt_key, evt_press, key_state[2]});
    else passes++;
    settle();
  endtask

  task automatic test_bounce();
    int a, b, c;
    logic seen;
    a = $urandom_range(3, 16);
    b = $urandom_range(1, 5);
    c = $urandom_range(3, 16);
    seen = 1'b0;
    ready = 1'b0;
    @(negedge clk);
    push[0] = 1'b0;
    repeat (a) begin @(negedge clk); seen |= key_state[0] | evt_valid; end
    push[0] = 1'b1;
    repeat (b) begin @(negedge clk); seen |= key_state[0] | evt_valid; end
    push[0] = 1'b0;
    repeat (c) begin @(negedge clk); seen |= key_state[0] | evt_valid; end
    push[0] = 1'b1;
    repeat (25) begin @(negedge clk); seen |= key_state[0] | evt_valid; end
    checks++;
    if (seen !== 1'b0)
      $display("FAIL bounce_filtered: got %b want 0 (a=%0d b=%0d c=%0d)",
               seen, a, b, c);
    else passes++;
    push[0] = 1'b0;
    repeat (23) @(negedge clk);
    checks++;
    if ({key_state[0], evt_valid, evt_key, evt_press} !== {2'b11, 2'd0, 1'b1})
      $display("FAIL bounce_press: got %b want 11001",
               {key_state[0], evt_valid, evt_key, evt_press});
    else passes++;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0)
      $display("FAIL bounce_single: got %b want 0", evt_valid);
    else passes++;
    settle();
  endtask

  task automatic test_simultaneous();
    logic [KW:0] ev [2];
    int at [2];
    int got;
    got = 0;
    ready = 1'b1;
    @(negedge clk);
    push[0] = 1'b0;
    push[3] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (evt_valid && got < 2) begin
        ev[got] = {evt_key, evt_press};
        at[got] = c;
        got++;
      end
    end
    checks++;
    if (got !== 2 || ev[0] !== {2'd0, 1'b1} || ev[1] !== {2'd3, 1'b1})
      $display("FAIL simultaneous: got n=%0d %b %b want 2 001 111",
               got, ev[0], ev[1]);
    else passes++;
    checks++;
    if (at[1] - at[0] !== 1)
      $display("FAIL simultaneous_gap: got %0d want 1", at[1] - at[0]);
    else passes++;
    settle();
  endtask

  task automatic test_back_to_back();
    logic [KW:0] exp_list [4];
    int n;
    exp_list[0] = {2'd1, 1'b1};
    exp_list[1] = {2'd2, 1'b1};
    exp_list[2] = {2'd3, 1'b1};
    exp_list[3] = {2'd1, 1'b0};
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) push[k] = 1'b0;
      else push[0] = 1'b1;
      repeat (DB + 6) begin
        @(negedge clk);
        checks++;
        if (obs() !== expv())
          $display("FAIL overflow_fill: got %h want %h", obs(), expv());
        else passes++;
      end
    end
    checks++;
    if ({evt_ovf, evt_valid, evt_key, evt_press} !== {2'b11, 2'd0, 1'b1})
      $display("FAIL overflow_set: got %b want 11001",
               {evt_ovf, evt_valid, evt_key, evt_press});
    else passes++;
    push[1] = 1'b1;
    n = 0;
    while (m_pend == '0 && n < 40) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 40) $display("FAIL sixth_timeout: got %0d want <40", n);
    else passes++;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    ovf_clr = 1'b1;
    checks++;
    if ({evt_ovf, evt_key, evt_press} !== {1'b1, 2'd1, 1'b1})
      $display("FAIL pop_write_full: got %b want 1011",
               {evt_ovf, evt_key, evt_press});
    else passes++;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if (evt_ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", evt_ovf);
    else passes++;
    ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (!evt_valid || {evt_key, evt_press} !== exp_list[j])
        $display("FAIL drain_%0d: got %b%b want 1%b",
                 j, evt_valid, {evt_key, evt_press}, exp_list[j]);
      else passes++;
      @(negedge clk);
    end
    ready = 1'b0;
    checks++;
    if (evt_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", evt_valid);
    else passes++;
    settle();
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat();
    int presses, releases;
    int at [8];
    presses = 0;
    releases = 0;
    ready = 1'b1;
    @(negedge clk);
    push[1] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 149) push[1] = 1'b1;
      if (evt_valid && evt_key == 2'd1) begin
        if (evt_press) begin
          if (presses < 8) at[presses] = c;
          presses++;
        end else releases++;
      end
    end
    checks++;
    if (presses !== 4 || releases !== 1)
      $display("FAIL repeat_count: got %0d/%0d want 4/1", presses, releases);
    else passes++;
    checks++;
    if (presses == 4 &&
        (at[1] - at[0] !== REP || at[2] - at[1] !== REP || at[3] - at[2] !== REP))
      $display("FAIL repeat_spacing: got %0d %0d %0d want %0d",
               at[1] - at[0], at[2] - at[1], at[3] - at[2], REP);
    else passes++;
    settle();
  endtask
`endif

  task automatic test_random();
    int tmr [NK];
    for (int k = 0; k < NK; k++) tmr[k] = $urandom_range(1, 45);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++;
      if (obs() !== expv())
        $display("FAIL random_c%0d: got %h want %h", c, obs(), expv());
      else passes++;
      for (int k = 0; k < NK; k++) begin
        tmr[k]--;
        if (tmr[k] == 0) begin
          push[k] = ~push[k];
          tmr[k] = $urandom_range(1, 45);
        end
      end
      if ((c % 400) < 150) ready = ($urandom_range(0, 7) == 0);
      else ready = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 20) == 0);
    end
    ready = 1'b0;
    ovf_clr = 1'b0;
  endtask

  initial begin
    m_drops = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_back_to_back();
`ifdef KEY_REPEAT_EN
    test_repeat();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
